fir_folded_mac: RTL and testbench

- Parametrised, time-multiplexed FIR filter and successor to the fixed 102-tap 3-parallel filter.
- Serves single-stream, lower-rate paths where area matters more than throughput.
- MACS multiply-accumulate lanes are reused over ceil(TAPS/MACS) cycles per output.
- Coefficients are runtime-loadable; input and output use valid/ready handshakes.
- Output is rounded, shifted and saturated to a configurable width.

---
 rtl/fir_folded_mac.sv | 191 +++++++++++++++++++
 tb/tb_fir_folded_mac.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_folded_mac.sv
// fir_folded_mac: time-multiplexed FIR filter.
//   A sample accepted in IDLE is shifted into the delay line, then MACS
//   multiply-accumulate lanes walk the taps in K = ceil(TAPS/MACS) groups
//   (one group per cycle in MAC). The accumulator is rounded, shifted and
//   saturated to OUT_W and presented in OUT until the downstream handshake.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     sample input handshake
//   out_valid/out_ready/out_data  result output handshake
//   out_sat                       result was clipped (qualified by out_valid)
//   coef_we/coef_addr/coef_wdata  coefficient write port (ignored in MAC)
//   busy                          high while accumulating

// One MAC lane: full-precision signed product, sign-extended to ACC_W.
module fir_mac_lane #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] h_i,
  output logic        [ACC_W-1:0]  p_o
);
  logic signed [DATA_W+COEF_W-1:0] prod;

  assign prod = x_i * h_i;
  assign p_o  = ACC_W'(prod);
endmodule

module fir_folded_mac #(
  parameter int TAPS   = 102,
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int MACS   = 3,
  parameter int ACC_W  = 64,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     busy
);
  localparam int K      = (TAPS + MACS - 1) / MACS;
  localparam int TAPS_P = K * MACS;
  localparam int IW     = $clog2(TAPS_P);
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int AW     = $clog2(TAPS);
  localparam int HS     = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] HALF = (SHIFT > 0) ? (ONE <<< HS) : '0;
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                        state_q, state_d;
  logic [TAPS-1:0][DATA_W-1:0]   x_q, x_d;
  logic [TAPS-1:0][COEF_W-1:0]   h_q;
  logic [TAPS_P-1:0][DATA_W-1:0] x_pad;
  logic [TAPS_P-1:0][COEF_W-1:0] h_pad;
  logic [MACS-1:0][ACC_W-1:0]    prod;
  logic [ACC_W-1:0]              acc_q, acc_d, lane_sum, acc_sum;
  logic [KW-1:0]                 k_q, k_d;
  logic [OUT_W-1:0]              out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic                          accept, last, in_mac, coef_ok;
  logic signed [ACC_W:0]         rnd, shf;

  assign in_mac  = (state_q == S_MAC);
  assign last    = (k_q == KW'(K - 1));
  assign coef_ok = coef_we && !in_mac;

  // Pad the tap arrays to a whole number of groups; pad entries read as
  // zero so lanes past the last tap add nothing.
  always_comb begin
    x_pad = '0;
    h_pad = '0;
    x_pad[TAPS-1:0] = x_q;
    h_pad[TAPS-1:0] = h_q;
  end

  for (genvar m = 0; m < MACS; m++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx = IW'(int'(k_q) * MACS + m);
    fir_mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane (
      .x_i (x_pad[idx]),
      .h_i (h_pad[idx]),
      .p_o (prod[m])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int m = 0; m < MACS; m++) lane_sum = lane_sum + prod[m];
  end
  assign acc_sum = acc_q + lane_sum;

  // Round half up on one extra bit so the rounding add cannot wrap.
  assign rnd = $signed({acc_sum[ACC_W-1], acc_sum}) + HALF;
  assign shf = rnd >>> SHIFT;

  always_comb begin
    out_sat_d  = 1'b0;
    out_data_d = shf[OUT_W-1:0];
    if (shf > OMAX) begin
      out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
      out_sat_d  = 1'b1;
    end else if (shf < OMIN) begin
      out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
      out_sat_d  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        busy = 1'b1;
        if (last) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    acc_d = acc_q;
    k_d   = k_q;
    if (accept) begin
      x_d   = {x_q[TAPS-2:0], in_data};
      acc_d = '0;
      k_d   = '0;
    end else if (in_mac) begin
      acc_d = acc_sum;
      k_d   = k_q + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      h_q        <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      if (in_mac && last) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
      // Addresses at or beyond TAPS match no entry and are dropped.
      for (int i = 0; i < TAPS; i++)
        if (coef_ok && coef_addr == AW'(i)) h_q[i] <= coef_wdata;
    end
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;
endmodule

// File: tb/tb_fir_folded_mac.sv
// Bench: three instances (TAPS=5, MACS=2) share stimulus and differ in
// output conversion: a = OUT_W 32/SHIFT 0, s = OUT_W 16/SHIFT 0,
// r = OUT_W 32/SHIFT 1. A reference model queues expected results at each
// accepted sample; a monitor pops them at each output handshake.
module tb_fir_folded_mac;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1;
  logic        coef_we = 0;
  logic [2:0]  coef_addr = '0;
  logic [31:0] coef_wdata = '0;

  logic a_ready, a_valid, a_sat, a_busy;
  logic s_ready, s_valid, s_sat, s_busy;
  logic r_ready, r_valid, r_sat, r_busy;
  logic [31:0] a_data, r_data;
  logic [15:0] s_data;

  always #5 clk = ~clk;

  fir_folded_mac #(.TAPS(5), .DATA_W(16), .COEF_W(32), .MACS(2), .ACC_W(64), .OUT_W(32), .SHIFT(0)) ua (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready), .in_data(in_data),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_sat(a_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(a_busy));
  fir_folded_mac #(.TAPS(5), .DATA_W(16), .COEF_W(32), .MACS(2), .ACC_W(64), .OUT_W(16), .SHIFT(0)) us (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
    .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data), .out_sat(s_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(s_busy));
  fir_folded_mac #(.TAPS(5), .DATA_W(16), .COEF_W(32), .MACS(2), .ACC_W(64), .OUT_W(32), .SHIFT(1)) ur (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_ready), .in_data(in_data),
    .out_valid(r_valid), .out_ready(out_ready), .out_data(r_data), .out_sat(r_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(r_busy));

  typedef struct { longint a; bit as; longint s; bit ss; longint r; bit rs; } res_t;

  res_t   exp_q[$];
  res_t   rx_q[$];
  res_t   mon_e, mon_g;
  longint mx[5];
  longint mh[5];
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic void conv(input longint acc, input int sh, input int ow,
                               output longint y, output bit sat);
    longint r, hi, lo;
    r   = acc + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
    y   = r >>> sh;
    hi  = (longint'(1) <<< (ow - 1)) - 1;
    lo  = -hi - 1;
    sat = 0;
    if (y > hi) begin y = hi; sat = 1; end
    else if (y < lo) begin y = lo; sat = 1; end
  endfunction

  function automatic void model_accept(input longint d);
    longint acc = 0;
    res_t e;
    for (int i = 4; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    for (int i = 0; i < 5; i++) acc += mx[i] * mh[i];
    conv(acc, 0, 32, e.a, e.as);
    conv(acc, 0, 16, e.s, e.ss);
    conv(acc, 1, 32, e.r, e.rs);
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin mx[i] = 0; mh[i] = 0; end
  endfunction

  // Handshake happens at the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    if (rst_n && a_valid && out_ready) begin
      mon_g.a = longint'($signed(a_data)); mon_g.as = a_sat;
      mon_g.s = longint'($signed(s_data)); mon_g.ss = s_sat;
      mon_g.r = longint'($signed(r_data)); mon_g.rs = r_sat;
      rx_q.push_back(mon_g);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got a=%0d s=%0d r=%0d required no output", mon_g.a, mon_g.s, mon_g.r);
      end else begin
        mon_e = exp_q.pop_front();
        if (!s_valid || !r_valid || mon_g.a !== mon_e.a || mon_g.as !== mon_e.as ||
            mon_g.s !== mon_e.s || mon_g.ss !== mon_e.ss || mon_g.r !== mon_e.r || mon_g.rs !== mon_e.rs) begin
          n_fail++;
          $display("FAIL sb_out got a=%0d/%0b s=%0d/%0b r=%0d/%0b (sv=%0b rv=%0b) required a=%0d/%0b s=%0d/%0b r=%0d/%0b",
                   mon_g.a, mon_g.as, mon_g.s, mon_g.ss, mon_g.r, mon_g.rs, s_valid, r_valid,
                   mon_e.a, mon_e.as, mon_e.s, mon_e.ss, mon_e.r, mon_e.rs);
        end
      end
    end
  end

  task automatic send(input longint d);
    int n = 0;
    in_valid = 1;
    in_data  = 16'(d);
    while (!a_ready && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (!a_ready) begin
      n_fail++;
      $display("FAIL send_timeout in_ready=%0b required=1", a_ready);
      in_valid = 0;
    end else begin
      model_accept(d);
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_coef(input int addr, input longint val);
    coef_we = 1; coef_addr = 3'(addr); coef_wdata = 32'(val);
    @(posedge clk); #1;
    coef_we = 0;
    if (addr < 5) mh[addr] = val;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_data !== 32'd0 || a_sat !== 1'b0 || a_busy !== 1'b0 ||
        s_valid !== 1'b0 || s_data !== 16'd0 || r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%0b vld=%0b data=%0d sat=%0b busy=%0b svld=%0b sdata=%0d rvld=%0b required rdy=1 others=0",
               a_ready, a_valid, a_data, a_sat, a_busy, s_valid, s_data, r_valid);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    longint want[6] = '{1, 2, 3, 4, 5, 0};
    for (int i = 0; i < 5; i++) write_coef(i, i + 1);
    rx_q.delete();
    send(1);
    for (int i = 0; i < 5; i++) send(0);
    drain();
    n_checks++;
    if (rx_q.size() != 6) begin
      n_fail++;
      $display("FAIL impulse_count got=%0d required=6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (rx_q[i].a !== want[i] || rx_q[i].as !== 1'b0) begin
          n_fail++;
          $display("FAIL impulse_%0d got=%0d sat=%0b required=%0d sat=0", i, rx_q[i].a, rx_q[i].as, want[i]);
        end
      end
    end
  endtask

  // Sample presented with in_ready in cycle t; busy in t+1..t+3, out_valid
  // in t+4, and with out_ready=1 the next sample is accepted in t+5.
  task automatic test_latency();
    in_valid = 1; in_data = 16'd0;
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready_t got=%0b required=1", a_ready); end
    model_accept(0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      in_valid = 0;
      n_checks++;
      if (a_busy !== 1'b1 || a_ready !== 1'b0 || a_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL lat_mac_t%0d got busy=%0b rdy=%0b vld=%0b required busy=1 rdy=0 vld=0", c, a_busy, a_ready, a_valid);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (a_valid !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_out_t4 got vld=%0b busy=%0b rdy=%0b required vld=1 busy=0 rdy=0", a_valid, a_busy, a_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_period_t5 got rdy=%0b vld=%0b required rdy=1 vld=0", a_ready, a_valid);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int n = 0;
    out_ready = 0;
    send(9);
    in_valid = 1; in_data = 16'd4;
    while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
    held = a_data;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_valid !== 1'b1 || a_data !== held || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got vld=%0b data=%0d rdy=%0b required vld=1 data=%0d rdy=0", c, a_valid, a_data, a_ready, held);
      end
    end
    out_ready = 1;
    send(4);
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) write_coef(i, 32767);
    rx_q.delete();
    send(32767);
    send(32767);
    for (int i = 0; i < 6; i++) send(-32768);
    drain();
    n_checks++;
    if (rx_q.size() != 8 || rx_q[0].s !== 32767 || rx_q[0].ss !== 1'b1 ||
        rx_q[7].s !== -32768 || rx_q[7].ss !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_values got n=%0d first=%0d/%0b last=%0d/%0b required n=8 first=32767/1 last=-32768/1",
               rx_q.size(), rx_q[0].s, rx_q[0].ss, rx_q[rx_q.size()-1].s, rx_q[rx_q.size()-1].ss);
    end
  endtask

  task automatic test_rounding();
    longint want[4] = '{2, 0, -1, 1};
    write_coef(0, 1);
    for (int i = 1; i < 5; i++) write_coef(i, 0);
    rx_q.delete();
    send(3); send(0); send(-3); send(2);
    drain();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_q.size() != 4 || rx_q[i].r !== want[i]) begin
        n_fail++;
        $display("FAIL round_%0d got=%0d required=%0d", i, (rx_q.size() > i) ? rx_q[i].r : 0, want[i]);
      end
    end
  endtask

  task automatic test_robust();
    // Coefficient write while accumulating must not land.
    rx_q.delete();
    send(7);
    coef_we = 1; coef_addr = 3'd0; coef_wdata = 32'd100;
    @(posedge clk); #1;
    coef_we = 0;
    drain();
    send(7);
    drain();
    // Address TAPS is out of range.
    write_coef(5, 99);
    send(1);
    drain();
    // Write and accept on the same edge: new coefficient applies.
    coef_we = 1; coef_addr = 3'd0; coef_wdata = 32'd3;
    mh[0] = 3;
    send(2);
    coef_we = 0;
    drain();
    n_checks++;
    if (rx_q.size() != 4 || rx_q[0].a !== 7 || rx_q[1].a !== 7 || rx_q[2].a !== 1 || rx_q[3].a !== 6) begin
      n_fail++;
      $display("FAIL robust_values got n=%0d v0=%0d v1=%0d v2=%0d v3=%0d required 7 7 1 6",
               rx_q.size(), rx_q[0].a, rx_q[1].a, rx_q[2].a, rx_q[3].a);
    end
  endtask

  task automatic test_reset_mid_mac();
    send(5);
    @(posedge clk); #1;
    rst_n = 0;
    exp_q.delete();
    model_reset();
    #1;
    n_checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async got vld=%0b rdy=%0b busy=%0b required vld=0 rdy=1 busy=0", a_valid, a_ready, a_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    n_checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release got vld=%0b rdy=%0b required vld=0 rdy=1", a_valid, a_ready);
    end
    rx_q.delete();
    send(1);
    for (int i = 0; i < 4; i++) send(0);
    drain();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx_q.size() != 5 || rx_q[i].a !== 0) begin
        n_fail++;
        $display("FAIL rst_zero_resp_%0d got=%0d required=0", i, (rx_q.size() > i) ? rx_q[i].a : -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_latency();
    test_backpressure();
    test_saturation();
    test_rounding();
    test_robust();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
